// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between the program counter and decode.
// Issues one synchronous instruction-memory read per cycle when there is room,
// tags the returning 16-bit instruction with its PC and queues it in a small
// FIFO that decode drains through a valid/ready handshake.
//
// Handshake: the head entry transfers to decode on a cycle where
// id_valid=1 and id_ready=1. While id_valid=1 and id_ready=0, id_instr and
// id_pc are held stable. While id_valid=0, id_ready is ignored and the head
// outputs keep the last value they showed.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cnt port, a
// 16-bit saturating count of cycles where decode stalls a valid head.
//
// dbg_state exposes the control FSM: 0 = S_BOOT, 1 = S_RUN, 2 = S_FLUSH.
module fetch_stage #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_hold,
   input  logic               flush,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]        stall_cnt,
`endif
   output logic [1:0]         dbg_state
);

   // Pointer width indexes DEPTH entries; the count needs one more bit so
   // that a completely full FIFO (count == DEPTH) is representable.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] L_DEPTH = (CNT_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // Control state
   state_t             r_state;
   logic               r_run;

   // In-flight read tracking
   logic               r_inflight;
   logic [ADDR_W-1:0]  r_tag;

   // FIFO storage and bookkeeping
   logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];
   logic [INSTR_W-1:0] r_fifo_instr [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   // Last values shown on the head outputs, replayed while the FIFO is empty
   logic [ADDR_W-1:0]  r_last_pc;
   logic [INSTR_W-1:0] r_last_instr;

   // Combinational control
   logic               w_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [CNT_W:0]     w_occ;
   logic [ADDR_W-1:0]  w_head_pc;
   logic [INSTR_W-1:0] w_head_instr;

   // Occupancy seen by the issue decision: buffered entries plus the read
   // still in flight, minus the entry decode takes this cycle. Because the
   // in-flight read always lands next cycle, bounding this by DEPTH is what
   // keeps the FIFO from overflowing.
   always_comb begin
      w_valid      = (r_count != '0);
      w_pop        = w_valid & id_ready;
      w_push       = r_inflight & ~flush;
      w_occ        = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
      w_issue      = ~rst & r_run & ~flush & (w_occ < L_DEPTH);
      w_head_pc    = r_fifo_pc[r_rd_ptr];
      w_head_instr = r_fifo_instr[r_rd_ptr];
   end

   assign imem_en   = w_issue;
   assign imem_addr = pc_addr;
   assign pc_hold   = ~w_issue;
   assign id_valid  = w_valid;
   assign id_pc     = w_valid ? w_head_pc    : r_last_pc;
   assign id_instr  = w_valid ? w_head_instr : r_last_instr;
   assign dbg_state = r_state;

   // Boot/run/flush sequencing; r_run is the registered "may issue" flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_BOOT;
         r_run   <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state <= S_RUN;
               r_run   <= 1'b1;
            end
            S_RUN: begin
               if (flush) begin
                  r_state <= S_FLUSH;
                  r_run   <= 1'b0;
               end else begin
                  r_state <= S_RUN;
                  r_run   <= 1'b1;
               end
            end
            S_FLUSH: begin
               r_state <= S_RUN;
               r_run   <= 1'b1;
            end
            default: begin
               r_state <= S_BOOT;
               r_run   <= 1'b0;
            end
         endcase
      end
   end

   // Track the single outstanding read and remember which PC it was for.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_inflight <= 1'b0;
         r_tag      <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_tag <= pc_addr;
         end
      end
   end

   // Capture returning read data, tagged with its PC, at the write pointer.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_tag;
         r_fifo_instr[r_wr_ptr] <= imem_rdata;
      end
   end

   // FIFO pointers and count; flush discards everything buffered.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Remember what the head outputs showed so they hold while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_pc    <= '0;
         r_last_instr <= '0;
      end else begin
         r_last_pc    <= id_pc;
         r_last_instr <= id_instr;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_stall_cnt;

   // Count cycles where decode holds off a valid head; saturate at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_valid && !id_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by a randomized run,
// with a queue-based reference model and a decoupled output monitor.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_addr;
  logic        pc_hold;
  logic        flush;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .pc_hold    (pc_hold),
    .flush      (flush),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents
  logic [15:0] mem [256];

  // Values sampled mid-cycle by the driver
  logic        hold_s, v_s, en_s;
  logic [7:0]  addr_s, pc_s;
  logic [15:0] instr_s;
  logic [1:0]  st_s;

  // ---------------- driver tasks ----------------
  // One clock cycle: apply inputs, sample mid-cycle, then model the memory
  // (data one cycle after the strobe) and the PC (advances unless held,
  // loads on redirect, clears on reset).
  task automatic cycle(input logic rdy, input logic fl, input logic rs,
                       input logic ld, input logic [7:0] ld_val);
    id_ready = rdy;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
    hold_s  = pc_hold;
    v_s     = id_valid;
    en_s    = imem_en;
    addr_s  = imem_addr;
    pc_s    = id_pc;
    instr_s = id_instr;
    st_s    = dbg_state;
    @(posedge clk);
    #1;
    if (en_s) imem_rdata = mem[addr_s];
    if (rs)          pc_addr = 8'd0;
    else if (ld)     pc_addr = ld_val;
    else if (!hold_s) pc_addr = pc_addr + 8'd1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  // With id_ready=1 from the first post-reset cycle, count cycles until the
  // first valid head and check what it carries.
  task automatic wait_first_valid(input string name, input int exp_n, input logic [15:0] exp_instr);
    int  n   = 0;
    bit  got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      if (i == 0) begin
        chk({name, "_hold_after_rst"},  32'(hold_s), 32'd1);
        chk({name, "_valid_after_rst"}, 32'(v_s),    32'd0);
        chk({name, "_boot_state"},      32'(st_s),   32'd0);
      end
      if (v_s) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    chk({name, "_latency"}, got ? 32'(n) : 32'd99, 32'(exp_n));
    chk({name, "_first_pc"},    32'(pc_s),    32'd0);
    chk({name, "_first_instr"}, 32'(instr_s), 32'(exp_instr));
  endtask

  // ---------------- reference model + scoreboard ----------------
  // exp_q holds {pc, instr} for every fetch issued and not yet delivered,
  // oldest first; the newest may still be in flight.
  logic [23:0] exp_q[$];
  int          m_count;   // entries decode could see
  int          m_infl;    // reads whose data arrives next cycle
  int          m_wait;    // cycles left before issuing is allowed
  logic [7:0]  last_pc;
  logic [15:0] last_instr;
  bit          m_pop, m_iss;

  initial begin
    m_count = 0; m_infl = 0; m_wait = 1;
    last_pc = 8'd0; last_instr = 16'd0;
  end

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      m_count = 0; m_infl = 0; m_wait = 1;
      exp_q.delete();
      last_pc = 8'd0; last_instr = 16'd0;
    end else begin
      m_pop = (m_count > 0) && id_ready;
      m_iss = (m_wait == 0) && !flush && ((m_count + m_infl - int'(m_pop)) < DEPTH);
      chk("pc_hold",  32'(pc_hold),  32'(!m_iss));
      chk("imem_en",  32'(imem_en),  32'(m_iss));
      chk("id_valid", 32'(id_valid), 32'(m_count > 0));
      if (m_iss) chk("imem_addr", 32'(imem_addr), 32'(pc_addr));
      if (flush) begin
        if (m_count > 0 && !m_pop && exp_q.size() > 0) begin
          last_pc    = exp_q[0][23:16];
          last_instr = exp_q[0][15:0];
        end
        m_count = 0;
        m_infl  = 0;
        exp_q.delete();
      end else begin
        m_count = m_count - int'(m_pop) + m_infl;
        m_infl  = int'(m_iss);
        if (m_iss) exp_q.push_back({pc_addr, mem[pc_addr]});
      end
      if (m_wait == 0 && flush) m_wait = 1;
      else if (m_wait > 0)      m_wait = m_wait - 1;
    end
  end

  // Monitor: compares whatever decode is shown against the scoreboard head
  // and retires it on a handshake.
  logic [23:0] popped;
  always begin
    @(negedge clk);
    if (!rst) begin
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: got id_pc %0h with nothing expected", id_pc);
        end else begin
          chk("head_pc",    32'(id_pc),    32'(exp_q[0][23:16]));
          chk("head_instr", 32'(id_instr), 32'(exp_q[0][15:0]));
          if (id_ready) begin
            popped     = exp_q.pop_front();
            last_pc    = popped[23:16];
            last_instr = popped[15:0];
          end
        end
      end else begin
        chk("empty_hold_pc",    32'(id_pc),    32'(last_pc));
        chk("empty_hold_instr", 32'(id_instr), 32'(last_instr));
      end
    end
  end

  // ---------------- stimulus ----------------
  int cnt;
  bit rnd_rdy, rnd_fl, rnd_rs;
  int r;

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    pc_addr = 8'd0; imem_rdata = 16'd0;
    for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);

    // 1: boot latency and steady-state throughput
    do_reset(3);
    wait_first_valid("boot", 3, 16'hA000);
    cnt = 0;
    repeat (20) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      cnt += int'(v_s);
    end
    chk("steady_no_gaps", 32'(cnt), 32'd20);

    // 2: decode stalled from the start
    do_reset(1);
    cnt = 0;
    repeat (10) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      cnt += int'(en_s);
    end
    chk("stall_issue_count", 32'(cnt), 32'(DEPTH));
    chk("stall_pc_hold",     32'(hold_s), 32'd1);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // 3: ready toggling every cycle
    for (int i = 0; i < 50; i++) cycle(1'(i % 2), 1'b0, 1'b0, 1'b0, 8'd0);

    // 4: flush with FIFO full and a read in flight, redirect to 8'h40
    do_reset(1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("flush_next_valid", 32'(v_s),    32'd0);
    chk("flush_next_hold",  32'(hold_s), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("flush_restart_en",   32'(en_s),   32'd1);
    chk("flush_restart_addr", 32'(addr_s), 32'h40);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // 5: one-cycle reset mid-stream behaves like power-up
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    do_reset(1);
    wait_first_valid("rst_mid", 3, 16'hA000);

    // Randomized run with random memory contents
    do_reset(1);
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      r       = $urandom_range(0, 99);
      rnd_rdy = ($urandom_range(0, 3) != 0);
      rnd_fl  = (r < 3);
      rnd_rs  = (r == 99);
      cycle(rnd_rdy, rnd_fl, rnd_rs, rnd_fl, 8'($urandom_range(0, 255)));
    end

`ifdef FETCH_PERF_CNT_EN
    // 6: stall counter counts stalled valid cycles and saturates
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      if (v_s) break;
    end
    repeat (9) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("stall_cnt_10", 32'(stall_cnt), 32'd10);
    repeat (70000) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
